// File: rtl/melody_player.sv
// Doorbell melody player: debounced doorbell/track buttons, IDLE/PLAY sequencer, square-wave tone output.
// Define MELODY_LED_EN to build the one-hot note indicator on LED; otherwise LED is tied to 0.
`timescale 1ns/1ps
module melody_player #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int STEP_CYCLES = 16_777_216,
    parameter int SEQ_LEN     = 32,
    parameter int NUM_TRACKS  = 5,
    parameter int REPEATS     = 1,
    parameter int DBNC_CYCLES = 500_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BTN_DRBL,
    input  logic        BTN_TRCK,
    output logic        BEEP,
    output logic [15:0] LED,
    output logic [2:0]  TRACK,
    output logic        BUSY,
    output logic        DONE
);
    localparam int STEP_W = $clog2(SEQ_LEN);
    localparam int PASS_W = $clog2(REPEATS) + 1;
    localparam int TMR_W  = $clog2(STEP_CYCLES + 1);
    localparam int DB_W   = $clog2(DBNC_CYCLES + 1);

    // Half-period in CLK cycles for a note code, scaled from the 50 MHz reference values.
    function automatic longint half_calc(input int code);
        longint h;
        case (code)
            1:  h = 63775;  2:  h = 56818;  3:  h = 50617;  4:  h = 47774;
            5:  h = 42567;  6:  h = 37919;  7:  h = 35790;  8:  h = 31887;
            9:  h = 28409;  10: h = 25308;  11: h = 23889;  12: h = 21282;
            13: h = 18960;
            default: h = 0;
        endcase
        h = (h * longint'(CLK_HZ)) / longint'(50_000_000);
        return (h < 1) ? longint'(1) : h;
    endfunction

    function automatic logic [3:0] note_code(input logic [2:0] trk, input logic [STEP_W-1:0] stp);
        int s;
        logic [3:0] nc;
        s  = int'(stp);
        nc = 4'd0;
        if (trk == 3'd0) begin
            case (s)
                0, 2, 4: nc = 4'd13;
                1, 3, 6: nc = 4'd12;
                5:       nc = 4'd10;
                7:       nc = 4'd11;
                8:       nc = 4'd9;
                default: nc = 4'd0;
            endcase
        end else if (trk == 3'd1 && s < 13) begin
            nc = 4'(s + 1);
        end
        return nc;
    endfunction

    localparam longint MAX_HALF = half_calc(1);
    localparam int     TONE_W   = $clog2(MAX_HALF + 1);

    logic [TONE_W-1:0] half_tbl [16];
    for (genvar c = 0; c < 16; c++) begin : g_half
        assign half_tbl[c] = TONE_W'(half_calc(c));
    end

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    logic [1:0]        sync1_q, sync2_q, lvl_q, lvl_d, press_q, press_d;
    logic [DB_W-1:0]   dbc_q [2];
    logic [DB_W-1:0]   dbc_d [2];
    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic [2:0]        track_q, track_d, ptrack_q, ptrack_d, track_inc;
    logic              beep_q, beep_d, done_q, done_d, restart;
    logic [3:0]        code;

    // Debounce: level follows the synchronized input only after DBNC_CYCLES differing samples in a row.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            lvl_d[b]   = lvl_q[b];
            press_d[b] = 1'b0;
            dbc_d[b]   = '0;
            if (sync2_q[b] != lvl_q[b]) begin
                if (dbc_q[b] == DB_W'(DBNC_CYCLES - 1)) begin
                    lvl_d[b]   = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    dbc_d[b] = dbc_q[b] + DB_W'(1);
                end
            end
        end
    end

    assign track_inc = (track_q == 3'(NUM_TRACKS - 1)) ? 3'd0 : track_q + 3'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            press_q  <= '0;
            dbc_q    <= '{default: '0};
            state_q  <= IDLE;
            step_q   <= '0;
            pass_q   <= '0;
            tmr_q    <= '0;
            tone_q   <= '0;
            track_q  <= '0;
            ptrack_q <= '0;
            beep_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sync1_q  <= {BTN_TRCK, BTN_DRBL};
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            press_q  <= press_d;
            dbc_q    <= dbc_d;
            state_q  <= state_d;
            step_q   <= step_d;
            pass_q   <= pass_d;
            tmr_q    <= tmr_d;
            tone_q   <= tone_d;
            track_q  <= track_d;
            ptrack_q <= ptrack_d;
            beep_q   <= beep_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        pass_d   = pass_q;
        tmr_d    = tmr_q;
        track_d  = track_q;
        ptrack_d = ptrack_q;
        done_d   = 1'b0;
        restart  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_q[1]) track_d = track_inc;
                if (press_q[0]) begin
                    state_d  = PLAY;
                    restart  = 1'b1;
                    ptrack_d = press_q[1] ? track_inc : track_q;
                    step_d   = '0;
                    pass_d   = '0;
                    tmr_d    = '0;
                end
            end
            PLAY: begin
                if (press_q[0]) begin
                    restart = 1'b1;
                    step_d  = '0;
                    pass_d  = '0;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(STEP_CYCLES - 1)) begin
                    restart = 1'b1;
                    tmr_d   = '0;
                    if (step_q == STEP_W'(SEQ_LEN - 1)) begin
                        step_d = '0;
                        if (pass_q == PASS_W'(REPEATS - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            pass_d  = '0;
                        end else begin
                            pass_d = pass_q + PASS_W'(1);
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Tone generator restarts from a low output at every start and step boundary.
        tone_d = '0;
        beep_d = 1'b0;
        if (state_q == PLAY && !restart && code != 4'd0) begin
            if (tone_q == half_tbl[code] - TONE_W'(1)) begin
                beep_d = ~beep_q;
            end else begin
                tone_d = tone_q + TONE_W'(1);
                beep_d = beep_q;
            end
        end
    end

    always_comb begin
        code = note_code(ptrack_q, step_q);
        BUSY = (state_q == PLAY);
    end

    assign BEEP  = beep_q;
    assign DONE  = done_q;
    assign TRACK = track_q;

`ifdef MELODY_LED_EN
    assign LED = (BUSY && code != 4'd0) ? (16'd1 << (code - 4'd1)) : 16'd0;
`else
    assign LED = 16'd0;
`endif
endmodule

// File: tb/tb_melody_player.sv
// Self-checking bench for melody_player: note table scoreboard plus hand-written retrigger/reset sequences.
`timescale 1ns/1ps
module tb_melody_player;
    localparam int CLK_HZ    = 500_000;
    localparam int STEP      = 2000;
    localparam int SEQ       = 4;
    localparam int REP       = 2;
    localparam int DBNC      = 4;
    localparam int PRESS_LAT = 3 + DBNC;   // 2 sync flops, DBNC samples, then the state register
    localparam int PLAY_LEN  = STEP * SEQ * REP;
`ifdef MELODY_LED_EN
    localparam bit LED_ON = 1'b1;
`else
    localparam bit LED_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, drbl, trck, drbl2;
    logic beep, busy, done, beep2, busy2, done2;
    logic [15:0] led, led2;
    logic [2:0] track, track2;

    always #5 clk = ~clk;

    melody_player #(.CLK_HZ(CLK_HZ), .STEP_CYCLES(STEP), .SEQ_LEN(SEQ), .NUM_TRACKS(5),
                    .REPEATS(REP), .DBNC_CYCLES(DBNC)) dut (
        .CLK(clk), .RST(rst), .BTN_DRBL(drbl), .BTN_TRCK(trck),
        .BEEP(beep), .LED(led), .TRACK(track), .BUSY(busy), .DONE(done));

    melody_player #(.CLK_HZ(CLK_HZ), .STEP_CYCLES(STEP), .SEQ_LEN(SEQ), .NUM_TRACKS(2),
                    .REPEATS(REP), .DBNC_CYCLES(DBNC)) dut2 (
        .CLK(clk), .RST(rst), .BTN_DRBL(drbl2), .BTN_TRCK(trck),
        .BEEP(beep2), .LED(led2), .TRACK(track2), .BUSY(busy2), .DONE(done2));

    typedef struct {
        int          track;
        int          step;
        int          half;
        logic [15:0] led;
    } vec_t;

    vec_t tbl [12];
    vec_t exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    // Monitor state, written only by the monitor process.
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;
    int done_abs = 0;
    logic busy_at_done = 1'b0;
    logic beep_seen = 1'b0;
    logic busy_prev = 1'b0;
    int rise = 0;
    logic [15:0] led_mid = '0;
    int meas_n = 0;
    int meas_rise [16];
    logic [15:0] meas_led [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        int off;
        int so;
        if (busy && !busy_prev) begin
            t0 = cyc;
            meas_n = 0;
            beep_seen = 1'b0;
        end
        busy_prev = busy;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_abs = cyc;
            busy_at_done = busy;
        end
        if (busy) begin
            off = cyc - t0;
            so  = off % STEP;
            if (beep) beep_seen = 1'b1;
            if (so == 0) rise = beep ? -1 : 0;
            else if (rise == 0 && beep) rise = so;
            if (so == STEP / 2) led_mid = led;
            if (so == STEP - 1) begin
                if (meas_n < 16) begin
                    meas_rise[meas_n] = rise;
                    meas_led[meas_n]  = led_mid;
                end
                meas_n = meas_n + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic press_trck();
        trck = 1'b1;
        repeat (10) @(negedge clk);
        trck = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Starts playback; trk >= 0 pushes the expected per-step notes of every pass.
    task automatic start_play(input int trk, input bit both);
        int c;
        if (trk >= 0)
            for (int p = 0; p < REP; p++)
                foreach (tbl[i]) if (tbl[i].track == trk) exp_q.push_back(tbl[i]);
        c = cyc;
        drbl = 1'b1;
        trck = both;
        repeat (10) @(negedge clk);
        drbl = 1'b0;
        trck = 1'b0;
        check("start_lat", t0, c + PRESS_LAT);
        check("start_busy", busy, 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int exp_abs);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < PLAY_LEN + 1000 && done_cnt == d0; i++) @(posedge clk);
        check({tag, "_done_seen"}, done_cnt, d0 + 1);
        check({tag, "_done_time"}, done_abs, exp_abs);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        repeat (5) @(negedge clk);
        check({tag, "_done_once"}, done_cnt, d0 + 1);
    endtask

    task automatic score(input string tag);
        int n;
        vec_t v;
        n = exp_q.size();
        check({tag, "_steps"}, meas_n, n);
        for (int i = 0; i < n; i++) begin
            v = exp_q.pop_front();
            check($sformatf("%s_p%0d_s%0d_half", tag, i / SEQ, v.step), meas_rise[i], v.half);
            check($sformatf("%s_p%0d_s%0d_led", tag, i / SEQ, v.step), meas_led[i],
                  LED_ON ? v.led : 16'h0);
        end
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, retrig, d0;
        tbl[0]  = '{0, 0, 189, 16'h1000};
        tbl[1]  = '{0, 1, 212, 16'h0800};
        tbl[2]  = '{0, 2, 189, 16'h1000};
        tbl[3]  = '{0, 3, 212, 16'h0800};
        tbl[4]  = '{1, 0, 637, 16'h0001};
        tbl[5]  = '{1, 1, 568, 16'h0002};
        tbl[6]  = '{1, 2, 506, 16'h0004};
        tbl[7]  = '{1, 3, 477, 16'h0008};
        tbl[8]  = '{2, 0, 0, 16'h0000};
        tbl[9]  = '{2, 1, 0, 16'h0000};
        tbl[10] = '{2, 2, 0, 16'h0000};
        tbl[11] = '{2, 3, 0, 16'h0000};

        rst = 1'b1; drbl = 1'b0; trck = 1'b0; drbl2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_beep", beep, 0);
        check("rst_led", led, 0);
        check("rst_track", track, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        trck = 1'b1;
        repeat (3) @(negedge clk);
        trck = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_track", track, 0);

        press_trck();
        check("track_1", track, 1);
        check("dut2_track_1", track2, 1);
        press_trck();
        check("track_2", track, 2);
        check("dut2_wrap", track2, 0);
        check("dut2_quiet", {beep2, busy2, done2, led2}, 0);

        start_play(2, 1'b0);
        wait_done("t2", t0 + PLAY_LEN);
        check("t2_mute_beep", beep_seen, 0);
        score("t2");

        press_trck();
        press_trck();
        press_trck();
        check("track_wrap", track, 0);

        start_play(0, 1'b0);
        wait_done("t0", t0 + PLAY_LEN);
        score("t0");

        // Simultaneous track and doorbell presses: playback must use the incremented track.
        start_play(1, 1'b1);
        check("coincide_track", track, 1);
        wait_done("t1", t0 + PLAY_LEN);
        score("t1");

        start_play(-1, 1'b0);
        while (cyc < t0 + 2 * STEP + 100) @(negedge clk);
        c = cyc;
        drbl = 1'b1;
        repeat (10) @(negedge clk);
        drbl = 1'b0;
        retrig = c + PRESS_LAT;
        check("retrig_busy", busy, 1);
        while (cyc < retrig + 636) @(negedge clk);
        check("retrig_quiet", beep, 0);
        @(negedge clk);
        check("retrig_rise", beep, 1);
        wait_done("retrig", retrig + PLAY_LEN);

        start_play(-1, 1'b0);
        while (cyc < t0 + STEP + 500) @(negedge clk);
        check("rst_pre_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_beep", beep, 0);
        check("rst_mid_led", led, 0);
        check("rst_mid_track", track, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (200) @(negedge clk);
        check("rst_no_done", done_cnt, d0);
        check("rst_stays_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
